// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode definitions: the queue entry layout and the opcode and
// function codes that identify control-transfer instructions.
package inst_queue_pkg;

  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        adel;
  } if_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-to-decode channel of the instruction queue. The master side is the
// surrounding pipeline (fetch pushes, decode pops); the slave side is the queue.
interface inst_queue_if #(
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_ins;
  logic             in_adel;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_ins;
  logic             out_adel;
  logic             out_bd;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_pc, in_ins, in_adel, out_ready,
    input  in_ready, out_valid, out_pc, out_ins, out_adel, out_bd, count
  );

  modport slave (
    input  in_valid, in_pc, in_ins, in_adel, out_ready,
    output in_ready, out_valid, out_pc, out_ins, out_adel, out_bd, count
  );

endinterface

// File: rtl/inst_queue_branch_classify.sv
// Flags jumps and branches, i.e. instructions whose successor sits in a
// branch delay slot. Takes only the opcode and function fields it needs.
module inst_queue_branch_classify
  import inst_queue_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       is_branch
);

  // Opcode decode; SPECIAL only counts for the register jumps
  always_comb begin
    is_branch = 1'b0;
    case (op)
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
        is_branch = 1'b1;
      OP_SPECIAL:
        is_branch = (func == FN_JR) || (func == FN_JALR);
      default:
        is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. Circular buffer of
// {pc, ins, adel} with a registered occupancy count, no fall-through path,
// and delay-slot tagging based on the last instruction handed to decode.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  inst_queue_if.slave  q
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  if_entry_t        mem [DEPTH];
  if_entry_t        head;
  if_entry_t        wentry;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W:0]   cnt;
  logic             last_br;
  logic             head_br;
  logic             push;
  logic             pop;

  // Handshake decisions use registered occupancy only, so in_ready never
  // depends on out_ready and a full queue cannot accept on a popping cycle.
  assign q.in_ready  = (cnt != CNT_FULL);
  assign q.out_valid = (cnt != '0);
  assign push        = q.in_valid && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;
  assign q.count     = cnt;

  assign wentry = '{pc: q.in_pc, ins: q.in_ins, adel: q.in_adel};
  assign head   = mem[rp];

  // Head presentation; an empty queue shows a NOP so decode sees nothing stale
  assign q.out_pc   = q.out_valid ? head.pc  : 32'h0;
  assign q.out_ins  = q.out_valid ? head.ins : NOP_INS;
  assign q.out_adel = q.out_valid && head.adel;
  assign q.out_bd   = q.out_valid && last_br;

  inst_queue_branch_classify u_classify (
    .op        (q.out_ins[31:26]),
    .func      (q.out_ins[5:0]),
    .is_branch (head_br)
  );

  // Control state: pointers, occupancy and delay-slot flag; flush outranks push/pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      last_br <= 1'b0;
    end else if (flush) begin
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      last_br <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + PTR_ONE;
      end
      if (pop) begin
        rp      <= rp + PTR_ONE;
        last_br <= head_br;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wp] <= wentry;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;

  int nvec = 0;
  int nerr = 0;

  if_entry_t mq[$];
  bit        mlast = 1'b0;

  inst_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .q      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Delay-slot rule: opcodes 1..7 are REGIMM/J/JAL/BEQ/BNE/BLEZ/BGTZ;
  // SPECIAL with func 8 or 9 is JR/JALR.
  function automatic bit ref_is_branch(input logic [31:0] ins);
    int op;
    int fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    if (op >= 1 && op <= 7) return 1'b1;
    if (op == 0 && (fn == 8 || fn == 9)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_model();
    bit        ev;
    if_entry_t h;
    ev = (mq.size() != 0);
    h  = ev ? mq[0] : '0;
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() < DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("out_pc",    64'(bus.out_pc),    64'(h.pc));
    chk("out_ins",   64'(bus.out_ins),   64'(h.ins));
    chk("out_adel",  64'(bus.out_adel),  64'(h.adel));
    chk("out_bd",    64'(bus.out_bd),    64'(ev && mlast));
    chk("count",     64'(bus.count),     64'(mq.size()));
  endtask

  // One clock: compare, apply one edge, update the model from pre-edge inputs
  task automatic step();
    bit        f;
    bit        pu;
    bit        po;
    if_entry_t e;
    check_model();
    f  = flush;
    pu = bus.in_valid && (mq.size() < DEPTH);
    po = bus.out_ready && (mq.size() != 0);
    e  = '{pc: bus.in_pc, ins: bus.in_ins, adel: bus.in_adel};
    @(posedge clk);
    #1;
    if (f) begin
      mq.delete();
      mlast = 1'b0;
    end else begin
      if (po) begin
        mlast = ref_is_branch(mq[0].ins);
        void'(mq.pop_front());
      end
      if (pu) mq.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit adel, input bit rdy);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_ins    = ins;
    bus.in_adel   = adel;
    bus.out_ready = rdy;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {6'b000100, r[25:0]};
      1: return {6'b000010, r[25:0]};
      2: return {6'b000000, r[25:6], 6'b001000};
      3: return {6'b000000, r[25:6], 6'b001001};
      4: return NOP_INS;
      5: return {6'b000001, r[25:0]};
      default: return r;
    endcase
  endfunction

  logic [31:0] bd_ins [6] = '{32'h1000_0003, 32'h0000_0000, 32'h2408_0002,
                              32'h03E0_0008, 32'h0000_0000, 32'h2408_0003};
  bit          bd_exp [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_ins",   64'(bus.out_ins),   64'd0);
    chk("rst_count",     64'(bus.count),     64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // First push is visible the cycle after
    drive(1'b1, 32'hBFC0_0000, 32'h2408_0001, 1'b0, 1'b0);
    step();
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_out_pc",    64'(bus.out_pc),    64'hBFC0_0000);
    chk("t1_out_ins",   64'(bus.out_ins),   64'h2408_0001);
    chk("t1_out_bd",    64'(bus.out_bd),    64'd0);
    chk("t1_count",     64'(bus.count),     64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();

    // Fill, blocked push, pop frees slot for next cycle, order through wrap
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h2400_0000 | 32'(i), 1'b0, 1'b0);
      step();
    end
    chk("t2_count_full", 64'(bus.count),    64'd4);
    chk("t2_in_ready",   64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'h110, 32'h2400_0004, 1'b0, 1'b0);
    step();
    chk("t2_blocked_count", 64'(bus.count), 64'd4);
    drive(1'b1, 32'h110, 32'h2400_0004, 1'b0, 1'b1);
    step();
    chk("t2_pop_count", 64'(bus.count), 64'd3);
    drive(1'b1, 32'h110, 32'h2400_0004, 1'b0, 1'b0);
    step();
    chk("t2_refill_count", 64'(bus.count), 64'd4);
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      chk("t2_order_pc", 64'(bus.out_pc), 64'h100 + 64'(4 * i));
      step();
    end

    // Delay-slot tagging after beq and jr
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) drive(1'b1, 32'h200 + 32'(4 * k), bd_ins[k], 1'b0, 1'b1);
      else       drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      if (k > 0) chk("t3_bd", 64'(bus.out_bd), 64'(bd_exp[k-1]));
      step();
    end

    // Flush with concurrent push and pop
    drive(1'b1, 32'h300, 32'h1000_0003, 1'b0, 1'b0); step();
    drive(1'b1, 32'h304, 32'h2408_0005, 1'b0, 1'b0); step();
    drive(1'b1, 32'h308, 32'h2408_0006, 1'b0, 1'b0); step();
    drive(1'b1, 32'h30C, 32'h2408_0007, 1'b0, 1'b1); step();
    chk("t4_bd_before_flush", 64'(bus.out_bd), 64'd1);
    chk("t4_count3",          64'(bus.count),  64'd3);
    drive(1'b1, 32'h310, 32'h2408_0008, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t4_count",     64'(bus.count),     64'd0);
    chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_out_ins",   64'(bus.out_ins),   64'd0);
    chk("t4_out_bd",    64'(bus.out_bd),    64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();

    // Steady stream: one in, one out per cycle
    drive(1'b1, 32'h1000, 32'h2408_0000, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'h2408_0000, 1'b0, 1'b1);
      chk("t5_count",  64'(bus.count),  64'd1);
      chk("t5_out_pc", 64'(bus.out_pc), 64'h1000 + 64'(4 * (i - 1)));
      step();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, rand_ins(),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0;

    // Asynchronous reset with two entries queued
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (DEPTH + 1) step();
    drive(1'b1, 32'h400, 32'h2408_0009, 1'b0, 1'b0); step();
    drive(1'b1, 32'h404, 32'h2408_000A, 1'b0, 1'b0); step();
    chk("t6_count2", 64'(bus.count), 64'd2);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_in_ready",  64'(bus.in_ready),  64'd1);
    chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_out_pc",    64'(bus.out_pc),    64'd0);
    chk("t6_out_ins",   64'(bus.out_ins),   64'd0);
    chk("t6_out_adel",  64'(bus.out_adel),  64'd0);
    chk("t6_out_bd",    64'(bus.out_bd),    64'd0);
    chk("t6_count",     64'(bus.count),     64'd0);
    mq.delete();
    mlast = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h0000_0001, 32'h2408_0001, 1'b1, 1'b0);
    step();
    chk("t6_adel",    64'(bus.out_adel), 64'd1);
    chk("t6_adel_pc", 64'(bus.out_pc),   64'h1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
